// File: rtl/mmap_m_axi_read_arbiter.sv
// Round-robin arbiter sharing one m_axi read channel among NUM_REQ requesters.
// Grant order is kept in an ordering FIFO so returned data is steered back to its issuer.
module mmap_m_axi_read_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ORDER_DEPTH = 8,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_len,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         out_REQ_ADDR,
  output logic [31:0]                   out_REQ_LEN,
  output logic                          out_REQ_VALID,
  input  logic                          in_REQ_READY,
  input  logic [DATA_WIDTH-1:0]         in_RDATA,
  input  logic                          in_RVALID,
  input  logic                          in_RLAST,
  output logic                          out_RREADY,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_last,
  input  logic [NUM_REQ-1:0]            rsp_ready
);
  localparam int PW = $clog2(ORDER_DEPTH);

  logic [ID_WIDTH-1:0]   rr_ptr, win, off, head;
  logic [ID_WIDTH:0]     sum;
  logic [2*NUM_REQ-1:0]  dbl;
  logic [ID_WIDTH-1:0]   fifo [ORDER_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [PW:0]           cnt;
  logic                  slot_free, full, nonempty, grant, pop;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [31:0]           win_len;

  // Rotate the valid vector so the scan always starts at rr_ptr.
  always_comb begin
    dbl = {req_valid, req_valid} >> rr_ptr;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (dbl[k]) off = ID_WIDTH'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (ID_WIDTH+1)'(NUM_REQ)) sum = sum - (ID_WIDTH+1)'(NUM_REQ);
    win = sum[ID_WIDTH-1:0];
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_WIDTH'(i) == win) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = req_len[i*32 +: 32];
      end
  end

  assign slot_free = ~out_REQ_VALID | in_REQ_READY;
  // Pre-pop count: a pop in the same cycle does not open a grant.
  assign full      = (cnt == (PW+1)'(ORDER_DEPTH));
  assign grant     = slot_free & ~full & (|req_valid);
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  assign nonempty   = (cnt != '0);
  assign head       = fifo[rptr];
  assign out_RREADY = nonempty & rsp_ready[head];
  assign rsp_valid  = (in_RVALID & nonempty) ? (NUM_REQ'(1) << head) : '0;
  assign rsp_data   = in_RDATA;
  assign rsp_last   = in_RLAST;
  assign pop        = in_RVALID & out_RREADY & in_RLAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_REQ_VALID <= 1'b0;
      out_REQ_ADDR  <= '0;
      out_REQ_LEN   <= '0;
      rr_ptr        <= '0;
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
    end else begin
      if (grant) begin
        out_REQ_VALID <= 1'b1;
        out_REQ_ADDR  <= win_addr;
        out_REQ_LEN   <= win_len;
        rr_ptr        <= (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        wptr          <= wptr + 1'b1;
      end else if (slot_free) begin
        out_REQ_VALID <= 1'b0;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({grant, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (grant) fifo[wptr] <= win;
endmodule

// File: tb/tb_mmap_m_axi_read_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a queue-based
// reference model of the arbiter evaluated every cycle.
module tb_mmap_m_axi_read_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*32-1:0]  req_len;
  logic [NR-1:0]     req_valid, req_ready;
  logic [AW-1:0]     out_REQ_ADDR;
  logic [31:0]       out_REQ_LEN;
  logic              out_REQ_VALID, in_REQ_READY;
  logic [DW-1:0]     in_RDATA, rsp_data;
  logic              in_RVALID, in_RLAST, out_RREADY, rsp_last;
  logic [NR-1:0]     rsp_valid, rsp_ready;

  mmap_m_axi_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ORDER_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .req_addr(req_addr), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready), .out_REQ_ADDR(out_REQ_ADDR),
    .out_REQ_LEN(out_REQ_LEN), .out_REQ_VALID(out_REQ_VALID), .in_REQ_READY(in_REQ_READY),
    .in_RDATA(in_RDATA), .in_RVALID(in_RVALID), .in_RLAST(in_RLAST), .out_RREADY(out_RREADY),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          m_q[$];
  int          m_rr;
  bit          m_vld;
  logic [AW-1:0] m_addr;
  logic [31:0] m_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Who wins this cycle (-1 = no grant), from the arbitration rules.
  function automatic int model_winner();
    if (!((!m_vld || in_REQ_READY) && m_q.size() < OD)) return -1;
    for (int k = 0; k < NR; k++) begin
      int j = (m_rr + k) % NR;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_model();
    int w;
    logic [NR-1:0] e_rdy, e_rv;
    bit e_rr;
    w = model_winner();
    e_rdy = '0;
    if (w >= 0) e_rdy[w] = 1'b1;
    e_rv = '0;
    e_rr = 1'b0;
    if (m_q.size() != 0) begin
      e_rr = rsp_ready[m_q[0]];
      if (in_RVALID) e_rv[m_q[0]] = 1'b1;
    end
    chk("req_ready", req_ready, e_rdy);
    chk("out_REQ_VALID", out_REQ_VALID, m_vld);
    if (m_vld) begin
      chk("out_REQ_ADDR", out_REQ_ADDR, m_addr);
      chk("out_REQ_LEN", out_REQ_LEN, m_len);
    end
    chk("out_RREADY", out_RREADY, e_rr);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data", rsp_data, in_RDATA);
    chk("rsp_last", rsp_last, in_RLAST);
  endtask

  task automatic update_model();
    int w;
    bit slot_free;
    w = model_winner();
    slot_free = !m_vld || in_REQ_READY;
    if (reset) begin
      m_q.delete(); m_rr = 0; m_vld = 0; m_addr = '0; m_len = '0;
      return;
    end
    if (m_q.size() != 0 && in_RVALID && rsp_ready[m_q[0]] && in_RLAST) void'(m_q.pop_front());
    if (w >= 0) begin
      m_vld = 1; m_addr = req_addr[w*AW +: AW]; m_len = req_len[w*32 +: 32];
      m_q.push_back(w);
      m_rr = (w + 1) % NR;
    end else if (slot_free) m_vld = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] held;
    m_rr = 0; m_vld = 0; m_addr = '0; m_len = '0;
    reset = 1; req_addr = '0; req_len = '0; req_valid = '0; in_REQ_READY = 0;
    in_RDATA = '0; in_RVALID = 0; in_RLAST = 0; rsp_ready = '0;
    @(posedge clk); #1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_out_valid", out_REQ_VALID, 1'b0);
    chk("rst_out_addr", out_REQ_ADDR, '0);
    chk("rst_rready", out_RREADY, 1'b0);
    chk("rst_req_ready", req_ready, '0);

    // Single requester, 4 beats
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h1000; req_len[0 +: 32] = 32'h40; in_REQ_READY = 1;
    #1 chk("t1_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("t1_out_valid", out_REQ_VALID, 1'b1);
    chk("t1_out_addr", out_REQ_ADDR, 32'h1000);
    in_RVALID = 1; rsp_ready = 2'b01;
    for (int b = 0; b < 4; b++) begin
      in_RLAST = (b == 3); in_RDATA = 32'hA0 + b;
      #1 chk("t1_rsp_valid", rsp_valid, 2'b01);
      tick();
    end
    in_RVALID = 0; in_RLAST = 0;
    #1 chk("t1_empty_rready", out_RREADY, 1'b0);

    // Round-robin with sustained grants and same-cycle pops
    req_valid = 2'b11; in_RVALID = 1; in_RLAST = 1; rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_alt", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = '0;
    tick();
    in_RVALID = 0; in_RLAST = 0;

    // Converter backpressure
    in_REQ_READY = 0; req_valid = 2'b01; req_addr[0 +: AW] = 32'h2222_0000;
    tick();
    held = out_REQ_ADDR;
    for (int k = 0; k < 5; k++) begin
      req_addr[0 +: AW] = $urandom;
      #1 chk("t3_no_grant", req_ready, '0);
      tick();
      chk("t3_stable", out_REQ_ADDR, held);
    end
    in_REQ_READY = 1;
    #1 chk("t3_release", req_ready, 2'b01);
    tick();
    req_valid = '0; in_RVALID = 1; in_RLAST = 1; rsp_ready = 2'b01;
    tick(); tick();
    in_RVALID = 0; in_RLAST = 0;

    // Ordering FIFO full
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) tick();
    #1 chk("t4_full", req_ready, '0);
    tick();
    in_RVALID = 1; in_RLAST = 1; rsp_ready = 2'b11;
    #1 chk("t4_pop_no_grant", req_ready, '0);
    chk("t4_pop_rready", out_RREADY, 1'b1);
    tick();
    in_RVALID = 0; in_RLAST = 0;
    #1 chk("t4_grant_after", req_ready, 2'b10);
    tick();

    // Steering and stall with FIFO holding 1,0
    req_valid = '0; in_RVALID = 1; in_RLAST = 1;
    for (int k = 0; k < 4; k++) tick();
    in_RVALID = 0; in_RLAST = 0;
    req_valid = 2'b10; tick();
    req_valid = 2'b01; tick();
    req_valid = '0; in_RVALID = 1; rsp_ready = 2'b01;
    #1 chk("t5_stall_rready", out_RREADY, 1'b0);
    chk("t5_stall_valid", rsp_valid, 2'b10);
    tick(); tick();
    rsp_ready = 2'b11;
    tick();
    in_RLAST = 1; tick();
    in_RLAST = 0;
    #1 chk("t5_next_head", rsp_valid, 2'b01);
    in_RVALID = 0;

    // Reset with outstanding requests and a held slot
    req_valid = 2'b11; in_REQ_READY = 0;
    tick();
    in_REQ_READY = 1; tick();
    in_REQ_READY = 0;
    chk("t6_pre_valid", out_REQ_VALID, 1'b1);
    reset = 1; tick();
    reset = 0;
    #1 chk("t6_valid", out_REQ_VALID, 1'b0);
    chk("t6_addr", out_REQ_ADDR, '0);
    chk("t6_len", out_REQ_LEN, '0);
    chk("t6_first_grant", req_ready, 2'b01);
    in_RVALID = 1;
    #1 chk("t6_rsp_valid", rsp_valid, '0);
    chk("t6_rready", out_RREADY, 1'b0);
    tick();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_addr[i*AW +: AW] = $urandom;
        req_len[i*32 +: 32]  = $urandom;
      end
      in_REQ_READY = ($urandom % 4) != 0;
      in_RVALID    = ($urandom % 2) != 0;
      in_RLAST     = ($urandom % 3) == 0;
      in_RDATA     = $urandom;
      rsp_ready    = NR'($urandom);
      reset        = ($urandom % 250) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
